// File: rtl/knn_result_reader.sv
// knn_result_reader: after the K-nearest list for a test point is final, scans the
// K slots, snapshots their labels and distances, majority-votes the class label and
// presents everything to the CPU as a small register map on the iob native bus.
// Optional feature: define KNN_RDOUT_IRQ_EN to add a level interrupt output `irq`
// (result_valid | overrun). Without it, software polls the status word at address 0.

module knn_result_reader #(
  parameter int K       = 4,
  parameter int LABEL_W = 4,
  parameter int DIST_W  = 32,
  parameter int ADDR_W  = 5,
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nb_done,
  output logic [IDX_W-1:0]   nb_rd_idx,
  input  logic               nb_valid,
  input  logic [LABEL_W-1:0] nb_label,
  input  logic [DIST_W-1:0]  nb_dist,
  input  logic               valid,
  input  logic [ADDR_W-1:0]  address,
  input  logic [3:0]         wstrb,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               busy
`ifdef KNN_RDOUT_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int BIN_W = $clog2(K + 1);
  localparam int NBINS = 2 ** LABEL_W;
  localparam logic [IDX_W-1:0]   SCAN_LAST = IDX_W'(K - 1);
  localparam logic [LABEL_W-1:0] VOTE_LAST = {LABEL_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, VOTE = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   hist [NBINS];
  logic [LABEL_W-1:0] vote_idx;
  logic [BIN_W-1:0]   best_cnt;
  logic [LABEL_W-1:0] best_lbl;
  logic [LABEL_W-1:0] win_label;
  logic [BIN_W-1:0]   win_votes;
  logic [LABEL_W-1:0] snap_label [K];
  logic [DIST_W-1:0]  snap_dist  [K];
  logic               result_valid, pending, overrun;
  logic               rv_next, pending_next, ovr_next;
  logic               start, accept, clear_wr;
  logic [31:0]        rd_word;

  assign start    = (state == IDLE) && (nb_done || pending);
  assign accept   = valid && !ready;
  assign clear_wr = accept && (wstrb != 4'd0) && (address == ADDR_W'(0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> SCAN (K cycles) -> VOTE (one cycle per bin) -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN; else state_next = IDLE;
      SCAN:    if (nb_rd_idx == SCAN_LAST) state_next = VOTE; else state_next = SCAN;
      VOTE:    if (vote_idx == VOTE_LAST) state_next = DONE; else state_next = VOTE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flag updates: DONE beats a simultaneous clear; a third request while busy is dropped and flagged.
  always_comb begin
    rv_next      = result_valid;
    pending_next = pending;
    ovr_next     = overrun;
    if (state == DONE)  rv_next = 1'b1;
    else if (start)     rv_next = 1'b0;
    else if (clear_wr)  rv_next = 1'b0;
    else                rv_next = result_valid;
    if (state == IDLE) begin
      // A new request landing while a queued one is being started stays queued.
      if (nb_done && pending) pending_next = 1'b1;
      else                    pending_next = 1'b0;
    end else begin
      if (nb_done) pending_next = 1'b1;
      else         pending_next = pending;
    end
    if (nb_done && pending && (state != IDLE)) ovr_next = 1'b1;
    else if (clear_wr)                         ovr_next = 1'b0;
    else                                       ovr_next = overrun;
  end

  // Scan, histogram and vote datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nb_rd_idx <= '0;
      vote_idx  <= '0;
      best_cnt  <= '0;
      best_lbl  <= '0;
      win_label <= '0;
      win_votes <= '0;
      for (int b = 0; b < NBINS; b++) hist[b] <= '0;
      for (int i = 0; i < K; i++) begin
        snap_label[i] <= '0;
        snap_dist[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nb_rd_idx <= '0;
            vote_idx  <= '0;
            best_cnt  <= '0;
            best_lbl  <= '0;
            for (int b = 0; b < NBINS; b++) hist[b] <= '0;
          end
        end
        SCAN: begin
          if (nb_valid) begin
            snap_label[nb_rd_idx] <= nb_label;
            snap_dist[nb_rd_idx]  <= nb_dist;
            hist[nb_label]        <= hist[nb_label] + BIN_W'(1);
          end else begin
            snap_label[nb_rd_idx] <= '0;
            snap_dist[nb_rd_idx]  <= {DIST_W{1'b1}};
          end
          nb_rd_idx <= (nb_rd_idx == SCAN_LAST) ? IDX_W'(0) : nb_rd_idx + IDX_W'(1);
        end
        VOTE: begin
          // Strictly greater keeps the earlier (lower) label on ties.
          if (hist[vote_idx] > best_cnt) begin
            best_cnt <= hist[vote_idx];
            best_lbl <= vote_idx;
          end
          vote_idx <= vote_idx + LABEL_W'(1);
        end
        DONE: begin
          win_label <= best_lbl;
          win_votes <= best_cnt;
        end
        default: ;
      endcase
    end
  end

  // CPU register map read mux (zero-extended words).
  always_comb begin
    rd_word = 32'd0;
    if (address == ADDR_W'(0))      rd_word = {29'd0, overrun, busy, result_valid};
    else if (address == ADDR_W'(1)) rd_word = 32'(win_label);
    else if (address == ADDR_W'(2)) rd_word = 32'(win_votes);
    else                            rd_word = 32'd0;
    for (int i = 0; i < K; i++) begin
      if (address == ADDR_W'(8 + i))  rd_word = 32'(snap_label[i]);
      if (address == ADDR_W'(16 + i)) rd_word = 32'(snap_dist[i]);
    end
  end

  // Flags, busy and bus response; non-status reads wait until the scan/vote finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      rdata        <= 32'd0;
    end else begin
      result_valid <= rv_next;
      pending      <= pending_next;
      overrun      <= ovr_next;
      busy         <= (state_next != IDLE);
      ready        <= 1'b0;
      rdata        <= 32'd0;
      if (accept) begin
        if (wstrb != 4'd0) begin
          ready <= 1'b1;
        end else if ((address == ADDR_W'(0)) || !busy) begin
          ready <= 1'b1;
          rdata <= rd_word;
        end
      end
    end
  end

`ifdef KNN_RDOUT_IRQ_EN
  // Level interrupt that follows the result/overrun flags until software clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= rv_next | ovr_next;
  end
`endif

endmodule
